shader_spi_loader: RTL
======================

SHADER_SPI_LOADER -- requirements
Module: shader_spi_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 16: number of shader memory words.
REQ-002 Parameter ADDR_WIDTH, default 4: memory address width, equal to log2(MEM_DEPTH).
REQ-003 clk_i  in  1  system clock; the only clock in the block.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 spi_sclk_i  in  1  SPI clock, asynchronous to clk_i, mode 0.
REQ-006 spi_mosi_i  in  1  SPI data in, MSB first.
REQ-007 spi_cs_i  in  1  SPI chip select, active-low.
REQ-008 spi_miso_o  out  1  SPI data out, MSB first.
REQ-009 mem_addr_o  out  ADDR_WIDTH  shader memory address for write and read.
REQ-010 mem_wdata_o  out  8  shader memory write data.
REQ-011 mem_we_o  out  1  single-cycle write strobe.
REQ-012 mem_rdata_i  in  8  memory read data; asynchronous read, valid in the same cycle as mem_addr_o.
REQ-013 busy_o  out  1  high while a transaction is active; used to pause shader execution.

Function
REQ-014 spi_sclk_i, spi_mosi_i and spi_cs_i SHALL each pass through a 2-flop synchronizer; SCLK edges SHALL be detected on the synchronized signal; sclk frequency <= clk_i/4.
REQ-015 FSM states: IDLE, CMD, WRITE, READ, DISCARD.
REQ-016 IDLE -> CMD on a synchronized CS falling edge; the bit counter and mem_addr_o are cleared to 0.
REQ-017 MOSI SHALL be sampled on SCLK rising edges; a byte completes on the 8th rising edge.
REQ-018 In CMD, a completed byte 0x00 -> WRITE, 0x01 -> READ, any other value -> DISCARD.
REQ-019 In WRITE, each completed byte SHALL drive mem_wdata_o and mem_we_o=1 for exactly one clk_i cycle, in the cycle after the 8th synchronized rising edge is detected; mem_addr_o then increments.
REQ-020 In READ, on entry the block SHALL load the MISO shift register from mem_rdata_i at address 0 and increment mem_addr_o; it SHALL reload after every 8th rising edge.
REQ-021 In READ, spi_miso_o SHALL update on SCLK falling edges, and the first bit SHALL be valid before the first rising edge of the data byte.
REQ-022 mem_addr_o SHALL wrap from MEM_DEPTH-1 to 0 in both WRITE and READ.
REQ-023 DISCARD SHALL ignore all bytes; no write occurs and spi_miso_o=0.
REQ-024 A CS rising edge in any state -> IDLE; a partial byte is discarded without a write.
REQ-025 busy_o=1 in every state except IDLE.
REQ-026 spi_miso_o=0 outside READ.
REQ-027 mem_we_o SHALL never assert outside WRITE.

Reset
REQ-028 rst_i=1 SHALL force: state IDLE, mem_addr_o=0, mem_wdata_o=0, mem_we_o=0, spi_miso_o=0, busy_o=0, bit counter 0, synchronizers to idle levels (CS=1, SCLK=0, MOSI=0).
REQ-029 Reset asserted mid-transaction SHALL abort it; the block resumes only at the next CS falling edge after reset.

Configuration
REQ-030 Macro SHADER_SPI_READBACK_EN: when defined, READ is implemented as specified.
REQ-031 When SHADER_SPI_READBACK_EN is undefined, command 0x01 SHALL go to DISCARD, spi_miso_o SHALL be tied to 0, and mem_rdata_i SHALL be unused.

Structure
REQ-032 Shared package shader_pkg SHALL hold the command constants CMD_WRITE=8'h00 and CMD_READ=8'h01, the FSM state enum, and the default MEM_DEPTH.
REQ-033 Sub-module spi_sync_edge: a 2-flop synchronizer plus rise/fall detection, instantiated for SCLK and CS; MOSI uses a synchronizer only.

Verification
REQ-034 CS low, send 0x00 then 0xA5, 0x3C, CS high -> mem_we_o pulses twice, (addr 0, 0xA5) then (1, 0x3C), each one cycle wide.
REQ-035 Write 17 bytes 0x00..0x10 -> the 17th write lands at addr 0 with data 0x10 (wrap-around).
REQ-036 Memory preloaded 0x11,0x22; send 0x01 then 16 dummy clocks -> MISO returns 0x11, 0x22 (READBACK_EN defined); with the macro undefined -> MISO returns 0x00, 0x00.
REQ-037 Command 0x00, then 5 bits, then CS high -> no mem_we_o pulse; the next transaction writes at addr 0.
REQ-038 Command 0x7F followed by 0xFF -> no write, MISO 0, busy_o high until CS rises.
REQ-039 rst_i asserted for 1 cycle after the 4th data bit of a write -> all outputs at reset values and no write occurs.

Source files
------------

// File: rtl/shader_pkg.sv
// Shared definitions for the shader SPI loader: command codes, FSM state
// encoding, the default memory depth and a shift helper.
package shader_pkg;

  localparam int unsigned SHADER_MEM_DEPTH = 16;

  localparam logic [7:0] CMD_WRITE = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_DISCARD
  } state_t;

  // Shift one new bit into the LSB (MSB-first serial reception).
  function automatic logic [7:0] shift_in_msb(input logic [7:0] sr, input logic b);
    return {sr[6:0], b};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with edge detection on the synchronized level.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset; all flops go to IDLE_LEVEL
//   async_i asynchronous input
//   sync_o  synchronized level (registered)
//   rise_c  one-cycle pulse on a synchronized rising edge (combinational)
//   fall_c  one-cycle pulse on a synchronized falling edge (combinational)
module spi_sync_edge #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q;
  logic prev_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= IDLE_LEVEL;
      sync_o <= IDLE_LEVEL;
      prev_q <= IDLE_LEVEL;
    end else begin
      meta_q <= async_i;
      sync_o <= meta_q;
      prev_q <= sync_o;
    end
  end

  assign rise_c = sync_o & ~prev_q;
  assign fall_c = ~sync_o & prev_q;

endmodule

// File: rtl/shader_spi_loader.sv
// SPI (mode 0) slave that loads and optionally reads back shader memory.
// First byte of a transaction is a command: 0x00 write, 0x01 read (only
// with SHADER_SPI_READBACK_EN defined), anything else is discarded.
// Ports:
//   clk_i, rst_i      system clock, synchronous active-high reset
//   spi_sclk_i        SPI clock (async to clk_i, <= clk_i/4)
//   spi_mosi_i        SPI data in, MSB first
//   spi_cs_i          SPI chip select, active-low
//   spi_miso_o        SPI data out, MSB first (0 outside READ)
//   mem_addr_o        shader memory address, wraps at MEM_DEPTH-1
//   mem_wdata_o       shader memory write data
//   mem_we_o          single-cycle write strobe
//   mem_rdata_i       asynchronous memory read data
//   busy_o            high while a transaction is active
// Configuration macro: SHADER_SPI_READBACK_EN enables the READ command.
module shader_spi_loader
  import shader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = SHADER_MEM_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_mosi_i,
  input  logic                  spi_cs_i,
  output logic                  spi_miso_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [7:0]            mem_rdata_i,
  output logic                  busy_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  logic       sclk_level_unused;
  logic       sclk_rise_c;
  logic       sclk_fall_c;
  logic       cs_sync;
  logic       cs_rise_c;
  logic       cs_fall_c;
  logic [1:0] mosi_sync_q;
  logic       mosi_s;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_in_q;
  logic [7:0] byte_next_c;
  logic       byte_last_c;
  logic [1:0] flush_q;
  logic       cs_armed_q;

  spi_sync_edge #(.IDLE_LEVEL(1'b0)) u_sclk_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (spi_sclk_i),
    .sync_o  (sclk_level_unused),
    .rise_c  (sclk_rise_c),
    .fall_c  (sclk_fall_c)
  );

  spi_sync_edge #(.IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (spi_cs_i),
    .sync_o  (cs_sync),
    .rise_c  (cs_rise_c),
    .fall_c  (cs_fall_c)
  );

  // MOSI only needs a level synchronizer; it is stable around SCLK rising edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) mosi_sync_q <= 2'b00;
    else       mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
  end
  assign mosi_s = mosi_sync_q[1];

  assign byte_next_c = shift_in_msb(shift_in_q, mosi_s);
  assign byte_last_c = (bit_cnt_q == 3'd7);

  // A CS already low when reset releases must not look like a fresh select:
  // wait until the synchronizer has flushed and seen CS high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_q    <= 2'd0;
      cs_armed_q <= 1'b0;
    end else begin
      if (!flush_q[1]) flush_q <= flush_q + 2'd1;
      if (flush_q[1] && cs_sync) cs_armed_q <= 1'b1;
    end
  end

`ifdef SHADER_SPI_READBACK_EN
  logic [7:0] shift_out_q;
  logic       miso_q;
  assign spi_miso_o = miso_q;
`else
  logic unused_readback;
  assign unused_readback = sclk_fall_c ^ (^mem_rdata_i);
  assign spi_miso_o      = 1'b0;
`endif

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_addr_o  <= '0;
      mem_wdata_o <= 8'h00;
      mem_we_o    <= 1'b0;
      busy_o      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'h00;
`ifdef SHADER_SPI_READBACK_EN
      shift_out_q <= 8'h00;
      miso_q      <= 1'b0;
`endif
    end else begin
      mem_we_o <= 1'b0;
      // Address advances after the strobe so the strobe sees a stable address.
      if (mem_we_o) mem_addr_o <= addr_inc(mem_addr_o);

      if (cs_rise_c) begin
        // Deselect aborts anything in flight, including a partial byte.
        state_q   <= ST_IDLE;
        busy_o    <= 1'b0;
        bit_cnt_q <= 3'd0;
`ifdef SHADER_SPI_READBACK_EN
        miso_q    <= 1'b0;
`endif
      end else begin
        if (state_q != ST_IDLE && sclk_rise_c) begin
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          shift_in_q <= byte_next_c;
        end

        case (state_q)
          ST_IDLE: begin
            if (cs_fall_c && cs_armed_q) begin
              state_q    <= ST_CMD;
              busy_o     <= 1'b1;
              bit_cnt_q  <= 3'd0;
              mem_addr_o <= '0;
            end
          end

          ST_CMD: begin
            if (sclk_rise_c && byte_last_c) begin
              if (byte_next_c == CMD_WRITE) begin
                state_q <= ST_WRITE;
`ifdef SHADER_SPI_READBACK_EN
              end else if (byte_next_c == CMD_READ) begin
                // Preload the first byte so its MSB goes out on the next SCLK fall.
                state_q     <= ST_READ;
                shift_out_q <= mem_rdata_i;
                mem_addr_o  <= addr_inc(mem_addr_o);
`endif
              end else begin
                state_q <= ST_DISCARD;
              end
            end
          end

          ST_WRITE: begin
            if (sclk_rise_c && byte_last_c) begin
              mem_we_o    <= 1'b1;
              mem_wdata_o <= byte_next_c;
            end
          end

`ifdef SHADER_SPI_READBACK_EN
          ST_READ: begin
            if (sclk_rise_c && byte_last_c) begin
              shift_out_q <= mem_rdata_i;
              mem_addr_o  <= addr_inc(mem_addr_o);
            end else if (sclk_fall_c) begin
              miso_q      <= shift_out_q[7];
              shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
          end
`endif

          default: begin
            // DISCARD: bytes are clocked in and ignored until CS rises.
          end
        endcase
      end
    end
  end

endmodule
